stream_demux: RTL and testbench

Parametrised, registered 1:N stream demultiplexer with valid/ready handshaking, optional packet locking and dropping of out-of-range selects. A single input stream is steered to one of NUM_CH output channels, each with its own one-entry output register, so a stalled channel never corrupts the others. It replaces the fixed combinational 1:4 demux wherever backpressure, data width or channel count matter: DMA fan-out and per-port routing.

---
 rtl/stream_demux.sv | 162 ++++++++++++++++
 tb/tb_stream_demux.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//   Registered 1:NUM_CH stream demultiplexer. One input stream is steered to one
//   of NUM_CH output channels. Each channel owns a one-entry output register, so
//   a stalled channel only blocks input beats aimed at that channel.
//
//   Handshake semantics (both sides): a beat transfers on a rising edge where
//   valid and ready are both 1. A source holds valid/data/last stable until the
//   transfer. s_ready is a function of registered state, s_sel and m_ready only.
//   It never depends on s_valid.
//
//   Optional packet locking (PKT_MODE=1): the channel is latched on the first
//   beat of a multi-beat packet and held until the beat carrying s_last. Beats
//   whose effective channel is >= NUM_CH are accepted and discarded, and each
//   one is counted in drop_cnt, which saturates.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   s_valid/s_ready   input handshake
//   s_data, s_last    input beat and end-of-packet flag
//   s_sel             target channel for the beat (for the first beat only
//                     when PKT_MODE=1)
//   m_valid/m_ready   per-channel output handshake, bit k is channel k
//   m_data            channel k is at [k*DATA_W +: DATA_W]
//   m_last            per-channel last flag
//   pkt_open          1 while a packet is in progress (FSM state, PKT_MODE=1)
//   drop_cnt          number of discarded beats, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module stream_demux #(
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 4,
  parameter int SEL_W    = $clog2(NUM_CH),
  parameter bit PKT_MODE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [SEL_W-1:0]         s_sel,
  input  logic                     s_last,
  output logic [NUM_CH-1:0]        m_valid,
  input  logic [NUM_CH-1:0]        m_ready,
  output logic [NUM_CH*DATA_W-1:0] m_data,
  output logic [NUM_CH-1:0]        m_last,
  output logic                     pkt_open,
  output logic [15:0]              drop_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    ch_q, ch_d;
  logic [NUM_CH-1:0]   full_q, full_d;
  logic [NUM_CH-1:0]   last_q, last_d;
  logic [DATA_W-1:0]   data_q [NUM_CH];
  logic [DATA_W-1:0]   data_d [NUM_CH];
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  logic [SEL_W-1:0]    ch;
  logic [NUM_CH-1:0]   ch_hit;
  logic                ch_invalid;
  logic                accept;

  // Effective channel, decoded one-hot. No bit is set when the channel is out
  // of range, which can only happen for non-power-of-two NUM_CH. The one-hot
  // form avoids indexing the per-channel vectors with an out-of-range value.
  always_comb begin
    ch = s_sel;
    if (PKT_MODE && (state_q == ST_OPEN)) begin
      ch = ch_q;
    end
    ch_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_hit[k] = (ch == SEL_W'(k));
    end
    ch_invalid = ~|ch_hit;
  end

  // A target register can take a beat when it is empty or is draining in this
  // same cycle. Beats with an invalid channel are always accepted and dropped.
  assign s_ready = ch_invalid | (|(ch_hit & (~full_q | m_ready)));
  assign accept  = s_valid & s_ready;

  always_comb begin
    full_d     = full_q;
    last_d     = last_q;
    data_d     = data_q;
    drop_cnt_d = drop_cnt_q;
    state_d    = state_q;
    ch_d       = ch_q;

    for (int k = 0; k < NUM_CH; k++) begin
      // A fill takes priority over a drain, so a drain and a fill in the same
      // cycle keep the register full with the new beat.
      if (accept && ch_hit[k]) begin
        full_d[k] = 1'b1;
        data_d[k] = s_data;
        last_d[k] = s_last;
      end else if (full_q[k] && m_ready[k]) begin
        full_d[k] = 1'b0;
      end
    end

    if (accept && ch_invalid && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    if (PKT_MODE && accept) begin
      case (state_q)
        ST_IDLE: begin
          // A single-beat packet (s_last on the first beat) never opens.
          if (!s_last) begin
            state_d = ST_OPEN;
            ch_d    = s_sel;
          end
        end
        ST_OPEN: begin
          if (s_last) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      full_q     <= '0;
      last_q     <= '0;
      drop_cnt_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      full_q     <= full_d;
      last_q     <= last_d;
      drop_cnt_q <= drop_cnt_d;
      for (int k = 0; k < NUM_CH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign m_valid  = full_q;
  assign m_last   = last_q;
  assign pkt_open = (state_q == ST_OPEN);
  assign drop_cnt = drop_cnt_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign m_data[k*DATA_W +: DATA_W] = data_q[k];
  end

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//   Two instances share clk/rst:
//     dut_a : NUM_CH=4, PKT_MODE=0 (steering, backpressure, throughput)
//     dut_b : NUM_CH=3, PKT_MODE=1 (packet lock, invalid select, reset mid-pkt)
//   Directed vectors carry hand-computed target channels. Accepted beats push
//   {last,data} into a per-channel expected queue, and a negedge monitor pops
//   the queue on every output handshake.
// -----------------------------------------------------------------------------
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_s_valid, a_s_ready, a_s_last, a_pkt_open;
  logic [7:0]  a_s_data;
  logic [1:0]  a_s_sel;
  logic [3:0]  a_m_valid, a_m_ready, a_m_last;
  logic [31:0] a_m_data;
  logic [15:0] a_drop_cnt;

  logic        b_s_valid, b_s_ready, b_s_last, b_pkt_open;
  logic [7:0]  b_s_data;
  logic [1:0]  b_s_sel;
  logic [2:0]  b_m_valid, b_m_ready, b_m_last;
  logic [23:0] b_m_data;
  logic [15:0] b_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Index is dut*4 + channel; each entry is {last, data}.
  logic [8:0] exp_q [8][$];

  stream_demux #(.DATA_W(8), .NUM_CH(4), .PKT_MODE(1'b0)) dut_a (
    .clk(clk), .rst(rst),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .s_sel(a_s_sel), .s_last(a_s_last),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .m_last(a_m_last), .pkt_open(a_pkt_open), .drop_cnt(a_drop_cnt)
  );

  stream_demux #(.DATA_W(8), .NUM_CH(3), .PKT_MODE(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .s_sel(b_s_sel), .s_last(b_s_last),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .m_last(b_m_last), .pkt_open(b_pkt_open), .drop_cnt(b_drop_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input int dut, input int ch, input logic [8:0] act);
    int idx;
    idx = dut * 4 + ch;
    if (exp_q[idx].size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_unexpected dut%0d ch%0d: actual=%0h required=none", dut, ch, act);
    end else begin
      check($sformatf("out dut%0d ch%0d", dut, ch), 32'(act), 32'(exp_q[idx].pop_front()));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (a_m_valid[c] && a_m_ready[c]) pop_check(0, c, {a_m_last[c], a_m_data[c*8 +: 8]});
    end
    for (int c = 0; c < 3; c++) begin
      if (b_m_valid[c] && b_m_ready[c]) pop_check(1, c, {b_m_last[c], b_m_data[c*8 +: 8]});
    end
  end

  // ---------------- driver ----------------
  // exp_ch < 0 means the beat must be dropped; exp_open < 0 skips the
  // pkt_open check at the acceptance cycle.
  task automatic send(input int dut, input logic [7:0] d, input logic [1:0] sel,
                      input logic last, input int exp_ch, input int exp_open,
                      output int stalls);
    logic rdy;
    stalls = 0;
    if (dut == 0) begin
      a_s_valid = 1'b1; a_s_data = d; a_s_sel = sel; a_s_last = last;
    end else begin
      b_s_valid = 1'b1; b_s_data = d; b_s_sel = sel; b_s_last = last;
    end
    @(negedge clk);
    rdy = (dut == 0) ? a_s_ready : b_s_ready;
    while (!rdy && stalls < 50) begin
      @(negedge clk);
      stalls++;
      rdy = (dut == 0) ? a_s_ready : b_s_ready;
    end
    check($sformatf("accept dut%0d data %0h", dut, d), 32'(rdy), 32'd1);
    if (exp_open >= 0) begin
      check($sformatf("pkt_open at %0h", d), 32'(b_pkt_open), 32'(exp_open));
    end
    if (rdy) begin
      @(posedge clk);
      if (exp_ch >= 0) exp_q[dut*4 + exp_ch].push_back({last, d});
      #1;
    end
    if (dut == 0) a_s_valid = 1'b0;
    else          b_s_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st, st_b0, st_b1, st_b2, tput_stalls, tput_cnt, first_i, last_i;
    logic [7:0] pkt_d   [4];
    logic [1:0] pkt_sel [4];

    rst = 1'b1;
    a_s_valid = 0; a_s_data = 0; a_s_sel = 0; a_s_last = 0; a_m_ready = 4'hF;
    b_s_valid = 0; b_s_data = 0; b_s_sel = 0; b_s_last = 0; b_m_ready = 3'h7;
    step(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst a_m_valid", 32'(a_m_valid), 0);
    check("rst a_m_data", a_m_data, 0);
    check("rst a_m_last", 32'(a_m_last), 0);
    check("rst a_s_ready", 32'(a_s_ready), 1);
    check("rst a_pkt_open", 32'(a_pkt_open), 0);
    check("rst a_drop_cnt", 32'(a_drop_cnt), 0);
    check("rst b_m_valid", 32'(b_m_valid), 0);
    check("rst b_m_data", 32'(b_m_data), 0);
    check("rst b_s_ready", 32'(b_s_ready), 1);
    check("rst b_pkt_open", 32'(b_pkt_open), 0);
    check("rst b_drop_cnt", 32'(b_drop_cnt), 0);
    step(1);

    // Basic steer: A0..A3 to channels 0..3, last on A3
    for (int i = 0; i < 4; i++) begin
      send(0, 8'hA0 + 8'(i), 2'(i), (i == 3), i, -1, st);
      check($sformatf("steer stall %0d", i), 32'(st), 0);
    end
    step(2);
    @(negedge clk);
    check("steer drained", 32'(a_m_valid), 0);
    step(1);

    // Backpressure isolation on channel 2
    a_m_ready = 4'b1011;
    fork
      begin
        send(0, 8'hB0, 2'd2, 1'b0, 2, -1, st_b0);
        send(0, 8'hB1, 2'd2, 1'b1, 2, -1, st_b1);
        send(0, 8'hB2, 2'd1, 1'b0, 1, -1, st_b2);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp s_ready", 32'(a_s_ready), 0);
        check("bp m_valid2", 32'(a_m_valid[2]), 1);
        check("bp hold data2", 32'(a_m_data[23:16]), 32'hB0);
        check("bp ch1 idle", 32'(a_m_valid[1]), 0);
        @(posedge clk);
        #1 a_m_ready[2] = 1'b1;
      end
    join
    check("bp stall b0", 32'(st_b0), 0);
    check("bp stall b1", 32'(st_b1), 2);
    check("bp stall b2", 32'(st_b2), 0);
    step(3);

    // Full throughput: 16 back-to-back beats to channel 0
    tput_stalls = 0; tput_cnt = 0; first_i = -1; last_i = -1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send(0, 8'h10 + 8'(i), 2'd0, (i == 15), 0, -1, st);
          tput_stalls += st;
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (a_m_valid[0] && a_m_ready[0]) begin
            tput_cnt++;
            if (first_i < 0) first_i = i;
            last_i = i;
          end
        end
      end
    join
    check("tput stalls", 32'(tput_stalls), 0);
    check("tput outputs", 32'(tput_cnt), 16);
    check("tput span", 32'(last_i - first_i + 1), 16);
    step(2);

    // Packet lock on dut_b: channel 1 latched, later selects ignored
    pkt_d   = '{8'h50, 8'h51, 8'h52, 8'h53};
    pkt_sel = '{2'd1, 2'd3, 2'd0, 2'd2};
    for (int i = 0; i < 4; i++) begin
      send(1, pkt_d[i], pkt_sel[i], (i == 3), 1, (i == 0) ? 0 : 1, st);
    end
    @(negedge clk);
    check("lock pkt_open end", 32'(b_pkt_open), 0);
    check("lock drop_cnt", 32'(b_drop_cnt), 0);
    step(2);

    // Invalid select: two single-beat drops, then a dropped 3-beat packet
    send(1, 8'h60, 2'd3, 1'b1, -1, 0, st);
    check("drop s_ready 1", 32'(st), 0);
    check("drop_cnt 1", 32'(b_drop_cnt), 1);
    send(1, 8'h61, 2'd3, 1'b1, -1, 0, st);
    check("drop s_ready 2", 32'(st), 0);
    check("drop_cnt 2", 32'(b_drop_cnt), 2);
    send(1, 8'h70, 2'd3, 1'b0, -1, 0, st);
    send(1, 8'h71, 2'd1, 1'b0, -1, 1, st);
    send(1, 8'h72, 2'd0, 1'b1, -1, 1, st);
    check("drop_cnt pkt", 32'(b_drop_cnt), 5);
    check("drop pkt closed", 32'(b_pkt_open), 0);
    check("drop no valid", 32'(b_m_valid), 0);
    step(1);

    // Reset mid-packet, then a fresh packet must follow its own select
    send(1, 8'h80, 2'd1, 1'b0, 1, 0, st);
    send(1, 8'h81, 2'd2, 1'b0, 1, 1, st);
    check("mid pkt_open", 32'(b_pkt_open), 1);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("mid rst m_valid", 32'(b_m_valid), 0);
    check("mid rst pkt_open", 32'(b_pkt_open), 0);
    check("mid rst drop_cnt", 32'(b_drop_cnt), 0);
    check("mid rst m_data", 32'(b_m_data), 0);
    step(1);
    send(1, 8'h90, 2'd2, 1'b0, 2, 0, st);
    send(1, 8'h91, 2'd0, 1'b1, 2, 1, st);
    step(3);
    @(negedge clk);
    check("post rst pkt_open", 32'(b_pkt_open), 0);

    // Every expected beat must have appeared
    for (int i = 0; i < 8; i++) begin
      check($sformatf("queue %0d empty", i), 32'(exp_q[i].size()), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
